// File: rtl/backscatter_pkg.sv
// Shared definitions for the backscatter frame scheduler: FSM encodings, default preamble, CRC-8 step.
// BS_CRC_EN (when defined) enables the CRC symbol state in the top level.
package backscatter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_PAYLOAD  = 3'd2,
        ST_CRC      = 3'd3,
        ST_GUARD    = 3'd4
    } state_e;

    localparam logic [7:0] PREAMBLE_DEFAULT = 8'b10101100;
    localparam logic [7:0] CRC8_POLY        = 8'h07;

    // One MSB-first bit of CRC-8, init 0, no reflection, no final XOR.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/backscatter_frame_sched_if.sv
// Request/status bundle between the frame requester and the scheduler.
// start/payload are sampled only while the scheduler is idle; busy/done report frame progress.
interface backscatter_frame_sched_if #(
    parameter int PAYLOAD_W = 16
);
    logic                 start;
    logic [PAYLOAD_W-1:0] payload;
    logic                 busy;
    logic                 done;

    modport master (output start, output payload, input busy, input done);
    modport slave  (input start, input payload, output busy, output done);
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser and stability counter for an active-low push button.
// Emits a one-cycle pulse when the debounced level falls (press).
module key_debounce #(
    parameter int DEBOUNCE_TICKS = 240000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic fall_o
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic          sync1_q, sync2_q, stable_q, fall_q;
    logic [CW-1:0] cnt_q;

    // Button idles high, so the synchroniser and stable level reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            fall_q  <= 1'b0;
            if (sync2_q != stable_q) begin
                if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                    stable_q <= sync2_q;
                    cnt_q    <= '0;
                    fall_q   <= ~sync2_q;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign fall_o = fall_q;
endmodule

// File: rtl/backscatter_frame_sched.sv
// Framed FSK transmitter for the RF switch array: preamble, payload, optional CRC-8, then guard.
// Define BS_CRC_EN to append the CRC-8 symbols after the payload.
module backscatter_frame_sched
    import backscatter_pkg::*;
#(
    parameter int         PAYLOAD_W      = 16,
    parameter logic [7:0] PREAMBLE       = PREAMBLE_DEFAULT,
    parameter int         BIT_TICKS      = 1200,
    parameter int         DIV_F0         = 6,
    parameter int         DIV_F1         = 3,
    parameter int         GUARD_TICKS    = 600,
    parameter int         DEBOUNCE_TICKS = 240000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      key0,
    backscatter_frame_sched_if.slave  bus,
    output logic                      ctrl1,
    output logic                      ctrl2,
    output logic                      ctrl3,
    output logic                      ctrl4,
    output logic                      led0,
    output state_e                    dbg_state_o
);
    localparam int TICK_MAX = (BIT_TICKS > GUARD_TICKS) ? BIT_TICKS : GUARD_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);
    localparam int DIV_MAX  = (DIV_F0 > DIV_F1) ? DIV_F0 : DIV_F1;
    localparam int DIV_W    = $clog2(DIV_MAX + 1);
    localparam int BITS_MAX = (PAYLOAD_W > 8) ? PAYLOAD_W : 8;
    localparam int BIT_W    = $clog2(BITS_MAX + 1);

    state_e               state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 phase_q, phase_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [7:0]           pre_q, pre_d;
    logic [PAYLOAD_W-1:0] pay_q, pay_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [3:0]           ctrl_q, ctrl_d;
`ifdef BS_CRC_EN
    logic [7:0]           crc_q, crc_d;
`endif

    logic             key_fall;
    logic             request;
    logic             sym_bit;
    logic             sym_end;
    logic [DIV_W-1:0] sym_div;

    key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_key_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_i  (key0),
        .fall_o (key_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            div_q   <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            pre_q   <= '0;
            pay_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ctrl_q  <= '0;
`ifdef BS_CRC_EN
            crc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            pre_q   <= pre_d;
            pay_q   <= pay_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ctrl_q  <= ctrl_d;
`ifdef BS_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        div_d   = div_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        pre_d   = pre_q;
        pay_d   = pay_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ctrl_d  = '0;
`ifdef BS_CRC_EN
        crc_d   = crc_q;
`endif
        request = bus.start | key_fall;
        sym_end = (tick_q == TICK_W'(BIT_TICKS - 1));

        case (state_q)
            ST_PREAMBLE: sym_bit = pre_q[7];
            ST_PAYLOAD:  sym_bit = pay_q[PAYLOAD_W-1];
`ifdef BS_CRC_EN
            ST_CRC:      sym_bit = crc_q[7];
`endif
            default:     sym_bit = 1'b0;
        endcase
        sym_div = sym_bit ? DIV_W'(DIV_F1 - 1) : DIV_W'(DIV_F0 - 1);

        case (state_q)
            ST_IDLE: begin
                if (request) begin
                    state_d = ST_PREAMBLE;
                    busy_d  = 1'b1;
                    pay_d   = bus.payload;
                    pre_d   = PREAMBLE;
                    tick_d  = '0;
                    div_d   = '0;
                    phase_d = 1'b1;
                    bit_d   = '0;
`ifdef BS_CRC_EN
                    crc_d   = '0;
`endif
                end
            end
`ifdef BS_CRC_EN
            ST_PREAMBLE, ST_PAYLOAD, ST_CRC: begin
`else
            ST_PREAMBLE, ST_PAYLOAD: begin
`endif
                // Bit 1 drives the f1 pair (ctrl3/4), bit 0 the f0 pair (ctrl1/2).
                ctrl_d = sym_bit ? {2'b00, phase_q, ~phase_q} : {phase_q, ~phase_q, 2'b00};
                if (sym_end) begin
                    tick_d  = '0;
                    div_d   = '0;
                    phase_d = 1'b1;
                    bit_d   = bit_q + BIT_W'(1);
                    case (state_q)
                        ST_PREAMBLE: begin
                            pre_d = {pre_q[6:0], 1'b0};
                            if (bit_q == BIT_W'(7)) begin
                                state_d = ST_PAYLOAD;
                                bit_d   = '0;
                            end
                        end
                        ST_PAYLOAD: begin
                            pay_d = {pay_q[PAYLOAD_W-2:0], 1'b0};
                            if (bit_q == BIT_W'(PAYLOAD_W - 1)) begin
`ifdef BS_CRC_EN
                                state_d = ST_CRC;
`else
                                state_d = ST_GUARD;
`endif
                                bit_d   = '0;
                            end
`ifdef BS_CRC_EN
                            crc_d = crc8_step(crc_q, sym_bit);
`endif
                        end
`ifdef BS_CRC_EN
                        ST_CRC: begin
                            crc_d = {crc_q[6:0], 1'b0};
                            if (bit_q == BIT_W'(7)) begin
                                state_d = ST_GUARD;
                                bit_d   = '0;
                            end
                        end
`endif
                        default: ;
                    endcase
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                    if (div_q == sym_div) begin
                        div_d   = '0;
                        phase_d = ~phase_q;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            ST_GUARD: begin
                if (tick_q == TICK_W'(GUARD_TICKS - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign led0        = busy_q;
    assign ctrl1       = ctrl_q[3];
    assign ctrl2       = ctrl_q[2];
    assign ctrl3       = ctrl_q[1];
    assign ctrl4       = ctrl_q[0];
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_backscatter_frame_sched.sv
// Self-checking bench for backscatter_frame_sched with small simulation timing parameters.
// Expected waveforms come from a symbol-level model of the frame (bits, tick position, half-period).
module tb_backscatter_frame_sched;
    import backscatter_pkg::*;

    localparam int PW = 16;
    localparam int BT = 16;
    localparam int DF0 = 4;
    localparam int DF1 = 2;
    localparam int GT = 8;
    localparam int DT = 4;
`ifdef BS_CRC_EN
    localparam int NSYM = 8 + PW + 8;
    localparam int EXP_LEN = 520;
`else
    localparam int NSYM = 8 + PW;
    localparam int EXP_LEN = 392;
`endif
    localparam int FRAME_LEN = NSYM * BT + GT;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   key0 = 1'b1;
    logic   ctrl1, ctrl2, ctrl3, ctrl4, led0;
    state_e dbg_state;

    backscatter_frame_sched_if #(.PAYLOAD_W(PW)) bus ();

    backscatter_frame_sched #(
        .PAYLOAD_W(PW), .PREAMBLE(8'b10101100), .BIT_TICKS(BT), .DIV_F0(DF0),
        .DIV_F1(DF1), .GUARD_TICKS(GT), .DEBOUNCE_TICKS(DT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key0(key0), .bus(bus),
        .ctrl1(ctrl1), .ctrl2(ctrl2), .ctrl3(ctrl3), .ctrl4(ctrl4),
        .led0(led0), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    logic frame_bits [0:31];

    typedef struct {
        logic [15:0] payload;
        int          exp_busy;
        int          exp_f1_syms;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_crc(input logic [15:0] d);
        logic [7:0] crc = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            logic fb = crc[7] ^ d[i];
            crc = crc << 1;
            if (fb) crc = crc ^ 8'h07;
        end
        return crc;
    endfunction

    // Fills frame_bits with the transmitted symbol sequence; returns the number of 1 symbols.
    function automatic int build_frame(input logic [15:0] pl);
        logic [7:0] pre = 8'b10101100;
        logic [7:0] crc = model_crc(pl);
        int ones = 0;
        for (int i = 0; i < 8; i++) frame_bits[i] = pre[7-i];
        for (int i = 0; i < PW; i++) frame_bits[8+i] = pl[PW-1-i];
        for (int i = 0; i < 8; i++) frame_bits[8+PW+i] = crc[7-i];
        for (int i = 0; i < NSYM; i++) ones += int'(frame_bits[i]);
        return ones;
    endfunction

    // Expected {busy, done, led0, ctrl1..4} j cycles after the accepting edge.
    function automatic logic [6:0] model_out(input int j);
        logic busy = (j < FRAME_LEN);
        logic done = (j == FRAME_LEN);
        logic [3:0] c = 4'b0000;
        int cyc = j - 1;
        if (j >= 1 && cyc < NSYM * BT) begin
            logic b = frame_bits[cyc / BT];
            int t = cyc % BT;
            int div = b ? DF1 : DF0;
            logic ph = ((t / div) % 2) == 0;
            c = b ? {2'b00, ph, !ph} : {ph, !ph, 2'b00};
        end
        return {busy, done, busy, c};
    endfunction

    task automatic pulse_start(input logic [15:0] pl);
        @(negedge clk);
        bus.start = 1'b1;
        bus.payload = pl;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic watch_frame(input logic [15:0] pl, input int exp_busy, input int exp_f1, input string tag);
        int waited = 0;
        int busy_cnt = 0;
        int f1_cyc = 0;
        void'(build_frame(pl));
        while (!bus.busy && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " accept timeout"}, 32'(waited < 64), 32'd1);
        if (waited >= 64) return;
        for (int j = 0; j <= FRAME_LEN + 1; j++) begin
            if (j > 0) @(negedge clk);
            check($sformatf("%s cyc j=%0d", tag, j),
                  32'({bus.busy, bus.done, led0, ctrl1, ctrl2, ctrl3, ctrl4}), 32'(model_out(j)));
            busy_cnt += int'(bus.busy);
            f1_cyc += int'(ctrl3 | ctrl4);
        end
        check({tag, " busy length"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, " f1 symbols"}, 32'(f1_cyc / BT), 32'(exp_f1));
    endtask

    task automatic expect_idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check($sformatf("%s idle i=%0d", tag, i), 32'({bus.busy, bus.done, ctrl1, ctrl2, ctrl3, ctrl4}), 32'd0);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.payload = '0;

`ifdef BS_CRC_EN
        tbl[0] = '{16'h0000, EXP_LEN, 4};
        tbl[1] = '{16'hFFFF, EXP_LEN, 22};
        tbl[2] = '{16'h0001, EXP_LEN, 8};
        tbl[3] = '{16'h8000, EXP_LEN, 10};
`else
        tbl[0] = '{16'h0000, EXP_LEN, 4};
        tbl[1] = '{16'hFFFF, EXP_LEN, 20};
        tbl[2] = '{16'h0001, EXP_LEN, 5};
        tbl[3] = '{16'h8000, EXP_LEN, 5};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("reset outputs", 32'({bus.busy, bus.done, led0, ctrl1, ctrl2, ctrl3, ctrl4}), 32'd0);
        check("reset state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        expect_idle(4, "post reset");

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            pulse_start(tbl[i].payload);
            watch_frame(tbl[i].payload, tbl[i].exp_busy, tbl[i].exp_f1_syms, $sformatf("tbl%0d", i));
        end

        // Random payloads against the model
        for (int i = 0; i < 3; i++) begin
            logic [15:0] pl = 16'($urandom_range(0, 65535));
            int ones = build_frame(pl);
            pulse_start(pl);
            watch_frame(pl, FRAME_LEN, ones, $sformatf("rnd%0d", i));
        end

        // Requests during busy, plus start and key0 together: one frame, accept-time payload
        begin
            logic [15:0] pl = 16'h5A3C;
            int ones = build_frame(pl);
            @(negedge clk);
            bus.start = 1'b1;
            bus.payload = pl;
            key0 = 1'b0;
            @(negedge clk);
            bus.start = 1'b0;
            fork
                watch_frame(pl, FRAME_LEN, ones, "busy_req");
                begin
                    for (int k = 0; k < 8; k++) begin
                        repeat ($urandom_range(5, 30)) @(negedge clk);
                        if (k == 0) key0 = 1'b1;
                        bus.start = 1'b1;
                        bus.payload = 16'($urandom_range(0, 65535));
                        @(negedge clk);
                        bus.start = 1'b0;
                    end
                end
            join
            expect_idle(20, "busy_req");
        end

        // Back-to-back: request in the done cycle is accepted
        begin
            int w = 0;
            logic [15:0] pl2 = 16'hC3A1;
            int ones2 = build_frame(pl2);
            pulse_start(16'h1111);
            while (!bus.done && w < FRAME_LEN + 16) begin
                @(negedge clk);
                w++;
            end
            check("b2b done seen", 32'(bus.done), 32'd1);
            bus.start = 1'b1;
            bus.payload = pl2;
            @(negedge clk);
            bus.start = 1'b0;
            check("b2b reaccept", 32'({bus.busy, bus.done}), 32'b10);
            watch_frame(pl2, FRAME_LEN, ones2, "b2b");
        end

        // Key glitches are ignored, a held press starts one frame
        begin
            logic [15:0] pl = 16'h0F0F;
            int ones = build_frame(pl);
            bus.payload = pl;
            for (int g = 0; g < 2; g++) begin
                @(negedge clk);
                key0 = 1'b0;
                expect_idle(2, "glitch low");
                key0 = 1'b1;
                expect_idle(5, "glitch high");
            end
            expect_idle(6, "glitch settle");
            @(negedge clk);
            key0 = 1'b0;
            fork
                watch_frame(pl, FRAME_LEN, ones, "key");
                begin
                    repeat (10) @(negedge clk);
                    key0 = 1'b1;
                end
            join
            expect_idle(20, "key");
        end

        // Reset mid-payload, then a fresh frame from the preamble
        begin
            logic [15:0] pl = 16'h9E37;
            int ones = build_frame(pl);
            pulse_start(16'h1234);
            repeat (200) @(negedge clk);
            check("pre-reset busy", 32'(bus.busy), 32'd1);
            check("pre-reset state", 32'(dbg_state), 32'(ST_PAYLOAD));
            #2 rst_n = 1'b0;
            #1;
            check("mid reset outputs", 32'({bus.busy, bus.done, led0, ctrl1, ctrl2, ctrl3, ctrl4}), 32'd0);
            check("mid reset state", 32'(dbg_state), 32'(ST_IDLE));
            @(negedge clk);
            rst_n = 1'b1;
            expect_idle(3, "after reset");
            pulse_start(pl);
            watch_frame(pl, FRAME_LEN, ones, "post_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
